mux4_rr_arbiter: RTL and testbench
==================================

Name: mux4_rr_arbiter

Overview:
- Shares one 4:1 multiplexed output path between four requesters using round-robin arbitration.
- Owns the mux select lines (s1, s0) and a registered output stage.
- Requester k places data on ik and raises req[k]. The block grants one requester at a time, steers ik to y, and flags valid.
- Sits between four producer blocks and a single downstream consumer.

Parameters:
- WIDTH, 8: data width of i0..i3 and y.
- MAX_HOLD, 4: maximum consecutive grant cycles per requester while others wait. Used only with MUX_ARB_TIMEOUT_EN; legal range 1..255.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request vector; req[k] asks for input ik.
- i0  input  WIDTH  data from requester 0.
- i1  input  WIDTH  data from requester 1.
- i2  input  WIDTH  data from requester 2.
- i3  input  WIDTH  data from requester 3.
- gnt  output  4  one-hot grant, registered.
- s1  output  1  select MSB, registered; {s1,s0} = index of the granted requester.
- s0  output  1  select LSB, registered.
- y  output  WIDTH  registered mux output.
- valid  output  1  y carries granted data.
- busy  output  1  high while in state GRANT.

Behaviour:
- Reset (rst=1 at a rising edge), regardless of state or mid-grant:
  - state=IDLE, gnt=0, s1=0, s0=0, y=0, valid=0, busy=0.
  - last_idx=3, so requester 0 wins first; hold_cnt=0.
- State machine has two states, IDLE and GRANT.
- IDLE:
  - gnt=0 and busy=0.
  - If req!=0, pick the first set bit searching last_idx+1, +2, +3, +4 (mod 4).
  - Next cycle: state=GRANT, gnt=onehot(k), {s1,s0}=k, last_idx=k, hold_cnt=0.
- GRANT, holding index k:
  - If req[k]=1 and no rotation is forced: keep the grant and increment hold_cnt (saturating).
  - If req[k]=0 and other requests are pending: regrant directly to the next requester in round-robin order after k, with no IDLE bubble, and reset hold_cnt to 0.
  - If req[k]=0 and no other request is pending: go to IDLE next cycle with gnt=0.
- Output stage:
  - Every cycle: y <= (state==GRANT) ? i[{s1,s0}] : y (hold last value), and valid <= (state==GRANT).
  - valid falls one cycle after the grant drops; y is not cleared.
- Latency:
  - req sampled at edge N gives gnt/select at N+1, and y/valid at N+2.
  - During the grant cycles y follows ik with 1-cycle delay.
- Arbitration rules:
  - Requests that arrive while a grant is held are only evaluated at release/rotation.
  - Simultaneous requests are resolved purely by round-robin order from last_idx; there is no fixed priority.
- Invariants: gnt is always one-hot or zero, and {s1,s0} always matches the set gnt bit. When gnt=0, {s1,s0} keeps its last value.
- A requester withdrawing req for one cycle loses the grant; re-requests take a new turn in the rotation.

Optional Feature:
- Macro: MUX_ARB_TIMEOUT_EN.
- Defined:
  - In GRANT, if hold_cnt==MAX_HOLD-1 and any other req bit is set, rotate to the next requester on the following edge even though req[k]=1.
  - If no other request is pending at that point, keep the grant and reset hold_cnt to 0.
- Not defined:
  - hold_cnt logic is absent and MAX_HOLD is ignored.
  - A requester keeps the grant until it drops req; starvation is possible by design.

Test Plan:
- Reset: rst=1 for 2 cycles with req=4'b1111 -> gnt=0, s1s0=00, y=0, valid=0 throughout; after rst=0, first gnt=4'b0001.
- Single requester: req=4'b0100, i2=8'hA5 for 3 cycles, then 0 -> gnt=0100 and s1s0=10 one cycle after req; y=A5 with valid=1 for 3 cycles starting 2 cycles after req; then IDLE and valid=0.
- Round-robin: req=4'b1111 held, each winner drops req after 1 grant cycle -> grant order 0,1,2,3, with no idle cycle between grants.
- Fairness: after requester 1 is served, req=4'b0011 -> gnt=0001, not 0010.
- Timeout (macro defined, MAX_HOLD=4): req=4'b1001 held constantly -> gnt alternates 0001 and 1000, 4 cycles each. Same stimulus without the macro -> gnt stays 0001.
- Reset mid-grant: rst=1 while gnt=0100 -> next cycle gnt=0, valid=0, y=0. After release with req=4'b0100, gnt=0100 within 1 cycle.

Source files
------------

// File: rtl/mux4_rr_arbiter_if.sv
// Bus between the four producers and the round-robin 4:1 mux arbiter.
// The producer side drives requests and data; the arbiter drives grant, select and the output stage.
interface mux4_rr_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       req;
    logic [WIDTH-1:0] i0;
    logic [WIDTH-1:0] i1;
    logic [WIDTH-1:0] i2;
    logic [WIDTH-1:0] i3;
    logic [3:0]       gnt;
    logic             s1;
    logic             s0;
    logic [WIDTH-1:0] y;
    logic             valid;
    logic             busy;

    modport master (
        output req, i0, i1, i2, i3,
        input  gnt, s1, s0, y, valid, busy
    );

    modport slave (
        input  req, i0, i1, i2, i3,
        output gnt, s1, s0, y, valid, busy
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a registered 4:1 mux output stage.
// Define MUX_ARB_TIMEOUT_EN to force rotation after MAX_HOLD consecutive grant cycles.
module mux4_rr_arbiter #(
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input logic              clk,
    input logic              rst,
    mux4_rr_arbiter_if.slave bus
);
    typedef enum logic {IDLE, GRANT} state_t;

    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("MAX_HOLD must be in 1..255");
    end

    state_t           state_q, state_d;
    logic [3:0]       gnt_q, gnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [WIDTH-1:0] y_q, y_mux;
    logic             valid_q;
    logic [3:0]       others;
`ifdef MUX_ARB_TIMEOUT_EN
    logic [7:0]       hold_q, hold_d;
`endif

    // First set bit of r searching base+1 .. base+4 (mod 4).
    function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] base);
        logic [1:0] pick;
        logic [1:0] idx;
        logic       found;
        pick  = base;
        found = 1'b0;
        for (int j = 1; j <= 4; j++) begin
            idx = base + 2'(j);
            if (!found && r[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    // In GRANT gnt_q is onehot(sel_q), so this masks off the current holder.
    assign others = bus.req & ~gnt_q;

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        sel_d   = sel_q;
        last_d  = last_q;
`ifdef MUX_ARB_TIMEOUT_EN
        hold_d  = hold_q;
`endif
        case (state_q)
            IDLE: begin
                gnt_d = 4'b0000;
                if (|bus.req) begin
                    state_d = GRANT;
                    sel_d   = rr_pick(bus.req, last_q);
                    last_d  = sel_d;
                    gnt_d   = 4'b0001 << sel_d;
`ifdef MUX_ARB_TIMEOUT_EN
                    hold_d  = '0;
`endif
                end
            end
            GRANT: begin
                if (!bus.req[sel_q]) begin
                    if (|others) begin
                        sel_d  = rr_pick(others, sel_q);
                        last_d = sel_d;
                        gnt_d  = 4'b0001 << sel_d;
`ifdef MUX_ARB_TIMEOUT_EN
                        hold_d = '0;
`endif
                    end else begin
                        state_d = IDLE;
                        gnt_d   = 4'b0000;
                    end
                end
`ifdef MUX_ARB_TIMEOUT_EN
                else if (hold_q == 8'(MAX_HOLD - 1)) begin
                    hold_d = '0;
                    if (|others) begin
                        sel_d  = rr_pick(others, sel_q);
                        last_d = sel_d;
                        gnt_d  = 4'b0001 << sel_d;
                    end
                end else if (hold_q != 8'hFF) begin
                    hold_d = hold_q + 8'd1;
                end
`endif
            end
            default: begin
                state_d = IDLE;
                gnt_d   = 4'b0000;
            end
        endcase
    end

    always_comb begin
        case (sel_q)
            2'd0:    y_mux = bus.i0;
            2'd1:    y_mux = bus.i1;
            2'd2:    y_mux = bus.i2;
            default: y_mux = bus.i3;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            gnt_q   <= 4'b0000;
            sel_q   <= 2'd0;
            last_q  <= 2'd3;
            y_q     <= '0;
            valid_q <= 1'b0;
`ifdef MUX_ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            // y holds its last value once the grant drops.
            y_q     <= (state_q == GRANT) ? y_mux : y_q;
            valid_q <= (state_q == GRANT);
`ifdef MUX_ARB_TIMEOUT_EN
            hold_q  <= hold_d;
`endif
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.s1    = sel_q[1];
    assign bus.s0    = sel_q[0];
    assign bus.y     = y_q;
    assign bus.valid = valid_q;
    assign bus.busy  = (state_q == GRANT);
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Scoreboard bench for mux4_rr_arbiter: directed scenarios plus random traffic
// against a behavioural owner/turn model of the round-robin rules.
module tb_mux4_rr_arbiter;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;
`ifdef MUX_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    typedef struct {
        logic [3:0]       gnt;
        logic [1:0]       sel;
        logic             busy;
        logic             valid;
        logic [WIDTH-1:0] y;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mux4_rr_arbiter_if #(.WIDTH(WIDTH)) bus ();
    mux4_rr_arbiter #(.WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (.clk(clk), .rst(rst), .bus(bus));

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;

    // Model: who owns the mux (-1 = nobody), whose turn was last, and how long the owner has held it.
    int               owner = -1;
    int               last  = 3;
    int               held  = 0;
    logic [1:0]       msel  = 2'd0;
    logic [WIDTH-1:0] my    = '0;
    logic             mvalid = 1'b0;

    function automatic int next_after(input logic [3:0] r, input int base);
        for (int d = 1; d <= 4; d++)
            if (r[(base + d) % 4]) return (base + d) % 4;
        return -1;
    endfunction

    task automatic give(input int k);
        owner = k;
        last  = k;
        held  = 1;
        msel  = 2'(k);
    endtask

    task automatic model_step(input logic r, input logic [3:0] rq, input logic [WIDTH-1:0] d [4]);
        logic [3:0] oth;
        exp_t e;
        if (r) begin
            owner = -1; last = 3; held = 0; msel = 2'd0; my = '0; mvalid = 1'b0;
        end else begin
            mvalid = (owner >= 0);
            if (owner >= 0) my = d[owner];
            if (owner < 0) begin
                if (rq != 4'b0) give(next_after(rq, last));
            end else begin
                oth = rq & ~(4'b0001 << owner);
                if (rq[owner]) begin
                    if (TO_EN && held == MAX_HOLD) begin
                        if (oth != 4'b0) give(next_after(oth, owner));
                        else held = 1;
                    end else begin
                        held++;
                    end
                end else if (oth != 4'b0) begin
                    give(next_after(oth, owner));
                end else begin
                    owner = -1;
                end
            end
        end
        e.gnt   = (owner >= 0) ? (4'b0001 << owner) : 4'b0000;
        e.sel   = msel;
        e.busy  = (owner >= 0);
        e.valid = mvalid;
        e.y     = my;
        q.push_back(e);
    endtask

    task automatic drive(input logic r, input logic [3:0] rq);
        logic [WIDTH-1:0] d [4];
        @(negedge clk);
        for (int k = 0; k < 4; k++) d[k] = WIDTH'($urandom);
        rst     = r;
        bus.req = rq;
        bus.i0  = d[0];
        bus.i1  = d[1];
        bus.i2  = d[2];
        bus.i3  = d[3];
        model_step(r, rq, d);
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Monitor: one expected snapshot per active edge, compared just after it.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gnt",   8'(bus.gnt), 8'(e.gnt));
                chk("sel",   8'({bus.s1, bus.s0}), 8'(e.sel));
                chk("busy",  8'(bus.busy), 8'(e.busy));
                chk("valid", 8'(bus.valid), 8'(e.valid));
                chk("y",     8'(bus.y), 8'(e.y));
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] rq;
        bus.req = 4'b0;
        bus.i0 = '0; bus.i1 = '0; bus.i2 = '0; bus.i3 = '0;

        // Reset with all requests up, then first grant goes to requester 0.
        drive(1'b1, 4'b1111);
        drive(1'b1, 4'b1111);
        drive(1'b0, 4'b1111);
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b0000);
        drive(1'b0, 4'b0000);

        // Single requester 2 for three cycles.
        repeat (3) drive(1'b0, 4'b0100);
        repeat (3) drive(1'b0, 4'b0000);

        // Back-to-back rotation with each winner dropping after one cycle.
        drive(1'b1, 4'b0000);
        drive(1'b0, 4'b1111);
        drive(1'b0, 4'b1110);
        drive(1'b0, 4'b1100);
        drive(1'b0, 4'b1000);
        repeat (2) drive(1'b0, 4'b0000);

        // Fairness: after requester 1, a 0011 request goes to requester 0.
        repeat (2) drive(1'b0, 4'b0010);
        drive(1'b0, 4'b0000);
        repeat (3) drive(1'b0, 4'b0011);
        repeat (2) drive(1'b0, 4'b0000);

        // Two requesters held constantly: timeout rotation or permanent hold.
        repeat (20) drive(1'b0, 4'b1001);
        repeat (2) drive(1'b0, 4'b0000);

        // Reset while requester 2 holds the grant.
        repeat (3) drive(1'b0, 4'b0100);
        drive(1'b1, 4'b0100);
        repeat (4) drive(1'b0, 4'b0100);
        repeat (2) drive(1'b0, 4'b0000);

        // Random traffic with sticky request patterns and rare resets.
        rq = 4'b0;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 9) < 3) rq = 4'($urandom);
            drive($urandom_range(0, 99) == 0, rq);
        end
        repeat (3) drive(1'b0, 4'b0000);

        @(posedge clk);
        #2;
        chk("drain", 8'(q.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
